// File: rtl/temporizador_bcd.sv
// Two-digit BCD countdown timer driving a dispense valve, with a multiplexed
// BCD output for a pair of 7-segment digits.
module temporizador_bcd #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_units,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic [1:0] dig_sel,
    output logic       valve,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        dig_sel_q, dig_sel_d;
    logic [3:0]        dcba_q, dcba_d;
    logic              valve_q, valve_d;
    logic              done_q, done_d;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        units_d = units_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                // load takes priority over start when both arrive together
                if (load) begin
                    tens_d  = clamp_bcd(preset_tens);
                    units_d = clamp_bcd(preset_units);
                end else if (start && ((tens_q != 4'd0) || (units_q != 4'd0))) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_HOLD;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (units_q != 4'd0) begin
                        units_d = units_q - 4'd1;
                    end else begin
                        units_d = 4'd9;
                        tens_d  = tens_q - 4'd1;
                    end
                    if ((tens_q == 4'd0) && (units_q == 4'd1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display mux follows the next-state count so digit and enable change together.
    always_comb begin
        scan_d    = scan_q;
        dig_sel_d = dig_sel_q;
        if (scan_q == SCAN_LAST) begin
            scan_d    = '0;
            dig_sel_d = {dig_sel_q[0], dig_sel_q[1]};
        end else begin
            scan_d = scan_q + SCAN_W'(1);
        end
        dcba_d  = dig_sel_d[1] ? tens_d : units_d;
        valve_d = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            tick_q    <= '0;
            scan_q    <= '0;
            dig_sel_q <= 2'b01;
            dcba_q    <= 4'd0;
            valve_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            tick_q    <= tick_d;
            scan_q    <= scan_d;
            dig_sel_q <= dig_sel_d;
            dcba_q    <= dcba_d;
            valve_q   <= valve_d;
            done_q    <= done_d;
        end
    end

    assign {D, C, B, A} = dcba_q;
    assign dig_sel      = dig_sel_q;
    assign valve        = valve_q;
    assign done         = done_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/temporizador_bcd.md
TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- TICK_DIV, 50000000, clk cycles per one-second tick.
- SCAN_DIV, 50000, clk cycles each digit is shown on the multiplexed display.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- load, in, 1, latch preset digits into the count (honoured in IDLE only).
- start, in, 1, begin the countdown (honoured in IDLE only).
- pause, in, 1, level; freezes the countdown while high.
- preset_tens, in, 4, BCD tens digit of the preset seconds.
- preset_units, in, 4, BCD units digit of the preset seconds.
- D, C, B, A, out, 1 each, BCD code of the currently scanned digit (D = MSB); feeds the 7-segment decoder inputs of the same names.
- dig_sel, out, 2, one-hot digit enable: [0] = units, [1] = tens.
- valve, out, 1, dispense valve drive; high only while counting.
- done, out, 1, one-cycle pulse when the count reaches 00.

Function
REQ-003 States: IDLE, RUN, HOLD, DONE, all encoded in one state register.

REQ-004 Load (IDLE only): on load=1, each preset digit is latched into tens/units.
- A digit >9 is clamped to 9.
- load in RUN, HOLD or DONE is ignored.

REQ-005 IDLE -> RUN: on start=1 with load=0 and count != 00.
- The tick prescaler is cleared on entry.
- start with count 00 leaves the block in IDLE; no done pulse.

REQ-006 Simultaneous load and start in IDLE: load is performed and start is ignored that cycle.

REQ-007 RUN tick: the prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1 it wraps to 0 and the count decrements by one in BCD:
- units != 0: units-1.
- units == 0: units = 9 and tens-1.

REQ-008 RUN -> DONE: on the cycle the decrement produces 00.

REQ-009 RUN -> HOLD: when pause=1.
- The prescaler and count are frozen.
- If pause and tick fall in the same cycle, pause wins: no decrement, prescaler holds TICK_DIV-1.

REQ-010 HOLD -> RUN: when pause=0; the prescaler resumes from its held value. start and load are ignored in HOLD.

REQ-011 DONE: lasts exactly one cycle with done=1, then -> IDLE with the count left at 00. done is 0 in every other state.

REQ-012 valve = 1 exactly when state is RUN, registered with the state register, so there is no combinational glitch.

REQ-013 Display scan, running in all states:
- The scan prescaler counts 0..SCAN_DIV-1; on wrap, dig_sel toggles between 01 and 10.
- {D,C,B,A} = units when dig_sel=01, tens when dig_sel=10.
- Outputs are registered and change in the same cycle as dig_sel.

REQ-014 The count never holds a non-BCD value (each digit 0..9 at all times).

Reset
REQ-015 When rst=1 at a clock edge, the following take effect that edge, overriding all other inputs:
- state = IDLE
- tens = 0, units = 0
- both prescalers = 0
- valve = 0, done = 0
- dig_sel = 01
- {D,C,B,A} = 0000

REQ-016 rst in RUN or HOLD aborts the countdown immediately: valve drops the next edge and no done pulse is issued.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-017 Load and run 12:
- Stimulus: load 1/2, then start.
- Response: valve=1 for 12×4 cycles; count steps 12, 11, 10, 09, ..., 00; 10→09 borrows correctly; done pulses one cycle; valve=0; state IDLE.

REQ-018 Clamp:
- Stimulus: load preset 0xC/0xF.
- Response: count reads 99.

REQ-019 Zero start, and load+start together:
- Stimulus: start with count 00.
- Response: no valve, no done.
- Stimulus: load 0/3 and start in the same cycle.
- Response: count 03, state stays IDLE.

REQ-020 Pause:
- Stimulus: pause for 10 cycles in RUN, including on a tick cycle.
- Response: count and valve frozen (valve=0), with no decrement lost or added after release; total RUN cycles unchanged.

REQ-021 Reset mid-run:
- Stimulus: rst at count 07.
- Response: next edge valve=0, count 00, dig_sel=01, DCBA=0000, no done.

REQ-022 Scan:
- Stimulus: count 58.
- Response: dig_sel alternates 01/10 every 2 cycles; DCBA alternates 1000 / 0101 with matching dig_sel.
